// File: rtl/mont_pkg.sv
// Shared constants, FSM state type and the elaboration-time Montgomery constant
// for the 2^255-19 reduction stage.
package mont_pkg;

   localparam int unsigned R_BITS = 258;
   localparam int unsigned PROD_W = 516;
   localparam int unsigned ACC_W  = 517;
   localparam int unsigned N_W    = 255;

   // 2^255 - 19
   localparam logic [N_W-1:0] N_MOD = {{247{1'b1}}, 8'hED};

   typedef enum logic [1:0] {
      StIdle,
      StRed,
      StDone
   } state_e;

   // -n^-1 mod 2^dw. Newton doubles the number of correct low bits on each pass,
   // so 8 passes starting from 1 cover any dw up to 129.
   function automatic logic [128:0] calc_np(input logic [N_W-1:0] n, input int unsigned dw);
      logic [128:0] mask;
      logic [128:0] nl;
      logic [128:0] x;
      mask = (129'd1 << dw) - 129'd1;
      nl   = n[128:0] & mask;
      x    = 129'd1;
      for (int i = 0; i < 8; i++) begin
         x = (x * (129'd2 - nl * x)) & mask;
      end
      return (129'd0 - x) & mask;
   endfunction

endpackage

// File: rtl/mont_digit_step.sv
// One radix-2^DW Montgomery reduction step: clears the low digit of the accumulator
// by adding q*N, then drops that digit.
module mont_digit_step
   import mont_pkg::*;
#(
   parameter int unsigned DW = 43
) (
   input  logic [ACC_W-1:0] i_acc,
   input  logic [DW-1:0]    i_np,
   input  logic [N_W-1:0]   i_n,
   output logic [ACC_W-1:0] o_acc
);

   logic [DW-1:0]     w_q;
   logic [DW+N_W-1:0] w_qn;
   logic [ACC_W-1:0]  w_sum;

   // Product evaluated at DW bits, so this is already mod 2^DW.
   assign w_q   = i_acc[DW-1:0] * i_np;
   assign w_qn  = {{N_W{1'b0}}, w_q} * {{DW{1'b0}}, i_n};
   assign w_sum = i_acc + {{(ACC_W-DW-N_W){1'b0}}, w_qn};
   assign o_acc = w_sum >> DW;

endmodule

// File: rtl/mont_redc_258_255.sv
// Word-serial Montgomery reduction (R = 2^258, N = 2^255-19) with valid/ready on both
// sides; result is left in [0, 2N) and not conditionally subtracted.
module mont_redc_258_255
   import mont_pkg::*;
#(
   parameter int unsigned DW = 43
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [R_BITS-1:0] res
);

   localparam int unsigned   NW      = R_BITS / DW;
   localparam int unsigned   CNT_W   = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [128:0]  NP_FULL = calc_np(N_MOD, DW);
   localparam logic [DW-1:0] NP      = NP_FULL[DW-1:0];

   state_e             r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic [ACC_W-1:0]   r_acc, w_acc_d;
   logic [R_BITS-1:0]  r_res, w_res_d;
   logic               r_out_valid, w_out_valid_d;
   logic [ACC_W-1:0]   w_acc_step;

   mont_digit_step #(
      .DW (DW)
   ) u_step (
      .i_acc (r_acc),
      .i_np  (NP),
      .i_n   (N_MOD),
      .o_acc (w_acc_step)
   );

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_acc_d       = r_acc;
      w_res_d       = r_res;
      w_out_valid_d = r_out_valid;
      in_ready      = 1'b0;
      unique case (r_state)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_acc_d   = {{(ACC_W-PROD_W){1'b0}}, prod};
               w_cnt_d   = '0;
               w_state_d = StRed;
            end
         end
         StRed: begin
            w_acc_d = w_acc_step;
            if (r_cnt == CNT_W'(NW - 1)) begin
               w_res_d       = w_acc_step[R_BITS-1:0];
               w_out_valid_d = 1'b1;
               w_state_d     = StDone;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         StDone: begin
            // A new product may be taken on the same edge the result is consumed.
            in_ready = out_ready;
            if (out_ready) begin
               w_out_valid_d = 1'b0;
               if (in_valid) begin
                  w_acc_d   = {{(ACC_W-PROD_W){1'b0}}, prod};
                  w_cnt_d   = '0;
                  w_state_d = StRed;
               end else begin
                  w_state_d = StIdle;
               end
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_res       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_acc       <= w_acc_d;
         r_res       <= w_res_d;
         r_out_valid <= w_out_valid_d;
      end
   end

   assign out_valid = r_out_valid;
   assign res       = r_res;

endmodule

// File: tb/tb_mont_redc_258_255.sv
// Directed and golden-model checks for the Montgomery reduction stage.
module tb_mont_redc_258_255;

   localparam logic [519:0] N_L    = (520'd1 << 255) - 520'd19;
   localparam logic [519:0] TWO_N  = 520'd2 * N_L;
   localparam logic [519:0] FOURNN = 520'd4 * N_L * N_L;
   localparam logic [515:0] R516   = 516'd1 << 258;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [515:0] prod = '0;
   logic         in_ready;
   logic         out_valid;
   logic [257:0] res;

   int total = 0;
   int bad   = 0;

   mont_redc_258_255 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prod      (prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   always #5 clk = ~clk;

   // Presents t and returns just after the accept edge.
   task automatic start_op(input logic [515:0] t, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      prod     = t;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      prod     = ~t;
   endtask

   task automatic wait_valid(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_one(input logic [515:0] t, output logic [257:0] r, output int lat,
                          output bit ok);
      bit ok1, ok2;
      start_op(t, ok1);
      wait_valid(lat, ok2);
      ok = ok1 && ok2;
      r  = res;
      drain();
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_out_valid got=%b want=0", out_valid);
      end
      total++;
      if (res !== '0) begin
         bad++;
         $display("FAIL reset_res got=%h want=0", res);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_zero();
      logic [257:0] r;
      int lat;
      bit ok;
      run_one('0, r, lat, ok);
      total++;
      if (!ok || lat != 6) begin
         bad++;
         $display("FAIL zero_latency got=%0d ok=%0d want=6", lat, ok);
      end
      total++;
      if (r !== '0) begin
         bad++;
         $display("FAIL zero_res got=%h want=0", r);
      end
   endtask

   task automatic test_exact();
      logic [515:0] tv [4];
      logic [257:0] ev [4];
      logic [257:0] r;
      int lat;
      bit ok;
      tv[0] = R516;
      ev[0] = 258'd1;
      tv[1] = R516 * 516'd5;
      ev[1] = 258'd5;
      tv[2] = {261'd0, N_L[254:0]};
      ev[2] = {3'd0, N_L[254:0]};
      tv[3] = R516 * TWO_N[515:0] - R516;
      ev[3] = TWO_N[257:0] - 258'd1;
      for (int i = 0; i < 4; i++) begin
         run_one(tv[i], r, lat, ok);
         total++;
         if (!ok || r !== ev[i]) begin
            bad++;
            $display("FAIL exact_%0d got=%h want=%h ok=%0d", i, r, ev[i], ok);
         end
      end
   endtask

   task automatic test_golden();
      logic [543:0] w;
      logic [543:0] tmp;
      logic [519:0] t520;
      logic [519:0] lhs;
      logic [519:0] rhs;
      logic [515:0] t;
      logic [257:0] r;
      int lat;
      bit ok;
      for (int k = 0; k < 1001; k++) begin
         if (k == 0) begin
            t520 = (TWO_N - 520'd1) * (TWO_N - 520'd1);
            t    = t520[515:0];
         end else begin
            for (int j = 0; j < 17; j++) w[j*32 +: 32] = $urandom;
            tmp = w % {24'd0, FOURNN};
            t   = tmp[515:0];
         end
         run_one(t, r, lat, ok);
         total++;
         if (!ok || {262'd0, r} >= TWO_N) begin
            bad++;
            $display("FAIL golden_bound_%0d got=%h ok=%0d", k, r, ok);
         end
         lhs = ({262'd0, r} << 258) % N_L;
         rhs = {4'd0, t} % N_L;
         total++;
         if (lhs !== rhs) begin
            bad++;
            $display("FAIL golden_mod_%0d got=%h want_congruent_to=%h", k, r, t);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [257:0] held;
      int lat;
      bit ok1, ok2;
      start_op(R516 * 516'd3, ok1);
      wait_valid(lat, ok2);
      held = res;
      total++;
      if (!(ok1 && ok2) || held !== 258'd3) begin
         bad++;
         $display("FAIL bp_res got=%h want=3", held);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         prod     = R516 * 516'd9;
         total++;
         if (out_valid !== 1'b1 || res !== held || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d got ov=%b res=%h rdy=%b want ov=1 res=3 rdy=0",
                     i, out_valid, res, in_ready);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got=%b want=0", out_valid);
      end
      repeat (9) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_ignored_input got ov=%b want=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [515:0] v [4];
      bit acc_now;
      int idx, nres, last;
      idx  = 0;
      nres = 0;
      last = 0;
      for (int i = 0; i < 4; i++) v[i] = R516 * 516'(2 * (i + 1));
      @(negedge clk);
      prod      = v[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && nres < 4; cyc++) begin
         acc_now = in_valid && in_ready;
         if (out_valid) begin
            total++;
            if (res !== 258'(2 * (nres + 1))) begin
               bad++;
               $display("FAIL b2b_res_%0d got=%h want=%0d", nres, res, 2 * (nres + 1));
            end
            if (nres > 0) begin
               total++;
               if (cyc - last != 7) begin
                  bad++;
                  $display("FAIL b2b_interval_%0d got=%0d want=7", nres, cyc - last);
               end
            end
            last = cyc;
            nres++;
         end
         @(posedge clk);
         #1;
         if (acc_now) begin
            idx++;
            if (idx < 4) prod = v[idx];
            else in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++;
      if (nres != 4) begin
         bad++;
         $display("FAIL b2b_count got=%0d want=4", nres);
      end
   endtask

   task automatic test_reset_mid();
      logic [257:0] r;
      int lat;
      bit ok, ok2;
      run_one(R516 * 516'd7, r, lat, ok);
      total++;
      if (!ok || r !== 258'd7) begin
         bad++;
         $display("FAIL rst_pre_res got=%h want=7", r);
      end
      start_op(R516 * 516'd5, ok);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || res !== '0) begin
         bad++;
         $display("FAIL rst_red got ov=%b res=%h want ov=0 res=0", out_valid, res);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_partial got ov=%b want=0", out_valid);
      end
      run_one(R516, r, lat, ok);
      total++;
      if (!ok || r !== 258'd1 || lat != 6) begin
         bad++;
         $display("FAIL rst_after got=%h lat=%0d want=1 lat=6", r, lat);
      end
      start_op(R516 * 516'd3, ok);
      wait_valid(lat, ok2);
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || res !== '0) begin
         bad++;
         $display("FAIL rst_done got ov=%b res=%h want ov=0 res=0", out_valid, res);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_zero();
      test_exact();
      test_golden();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
